power_bank: RTL and testbench
=============================

# power_bank

Multi-channel, parametrised power-level accumulator with saturating charge/drain and a depletion lockout per channel. Each channel holds a level register that drains at a rate chosen by a 2-bit power setting (Off/Single/Double/Hilted) or recharges at the same rate. All channels update on a shared programmable tick. The block replaces the single-channel 8-bit power register in the power subsystem and feeds level and status flags to the display and ALU control logic.

## Interface
- NUM_CH, 2, number of independent channels
- WIDTH, 8, level register width in bits
- MAX_LEVEL, 179, saturation ceiling; must satisfy 0 < MAX_LEVEL ≤ 2^WIDTH−1
- RECOVER_LEVEL, 16, level at or above which a locked-out channel returns to NORMAL; must satisfy 0 < RECOVER_LEVEL ≤ MAX_LEVEL
- TICK_DIV, 1, number of clk cycles per update tick; TICK_DIV ≥ 1
- RATE1 / RATE2 / RATE3, 1 / 2 / 3, per-tick delta for settings 1/2/3; setting 0 (Off) is always delta 0
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of all channels
- powerSetting  in  2*NUM_CH  per-channel setting; channel i uses bits [2i+1:2i]
- powerMode  in  NUM_CH  per-channel direction; 1 = drain, 0 = charge
- powerOutput  out  WIDTH*NUM_CH  per-channel level; channel i uses bits [WIDTH*i+WIDTH-1:WIDTH*i]
- full  out  NUM_CH  level == MAX_LEVEL
- empty  out  NUM_CH  level == 0
- lockout  out  NUM_CH  channel is in the LOCKOUT state
- active  out  NUM_CH  channel is draining with nonzero rate in NORMAL and level > 0
- tick  out  1  high on the cycle in which levels update

## Operation
- Tick divider: counter 0..TICK_DIV−1, wraps to 0. tick = (counter == TICK_DIV−1). With TICK_DIV = 1, tick is constant 1 after reset.
- Rate select: delta = 0, RATE1, RATE2 or RATE3 for setting 0..3.
- Arithmetic uses WIDTH+1 bits internally. Charge: level ← min(level + delta, MAX_LEVEL). Drain: level ← max(level − delta, 0). Neither direction wraps.
- Per-channel FSM with two states, NORMAL and LOCKOUT:
  - NORMAL, drain: apply drain. If the result is 0 and delta > 0, go to LOCKOUT in the same update.
  - NORMAL, charge: apply charge and stay in NORMAL.
  - LOCKOUT, drain: the request is ignored; level holds.
  - LOCKOUT, charge: apply charge. If the new level is ≥ RECOVER_LEVEL, go to NORMAL.
- When tick = 0, levels and states hold.
- clr has priority over tick. It sets all levels to 0, all states to NORMAL and the counter to 0 on the next edge.
- rst low at any time forces the reset state immediately, including in the middle of a tick or a lockout.
- Channels are fully independent; only the divider is shared.
- full, empty, lockout and active are combinational decodes of the registered level and state. active = powerMode & (setting ≠ 0) & NORMAL & (level ≠ 0).

## Timing
- Reset values:
  - every powerOutput lane = 0
  - all states = LOCKOUT if RECOVER_LEVEL > 0, which it always is; a channel must be charged to RECOVER_LEVEL before it may drain after reset
  - counter = 0
  - full = 0, empty = all 1, lockout = all 1, active = 0
  - tick = 1 if TICK_DIV = 1, else 0
- powerSetting and powerMode are sampled at the rising edge where tick = 1. The new level is visible one cycle later (latency 1).
- With TICK_DIV = N, consecutive updates are exactly N cycles apart. The first update after reset or clr occurs on the N-th rising edge.
- Flags follow powerOutput with zero additional latency.

## Test plan
- Reset then charge: TICK_DIV=1, rst released, ch0 charge setting 3 for 6 cycles → levels 3, 6, …, 18. lockout[0] drops on the cycle level becomes 18 (≥ 16).
- Saturation at top: ch0 at 178, charge setting 2 → 179 and full[0]=1. Further charge cycles hold 179.
- Drain to empty and lockout: ch1 at 5 in NORMAL, drain setting 3 → 2, then 0. lockout[1]=1 and empty[1]=1. Further drain requests keep the level at 0 and active[1]=0.
- Divider timing: TICK_DIV=4, ch0 at 100 in NORMAL, drain setting 1 → level changes only every 4th edge: 99, 98, …. tick is a 1-cycle pulse with period 4.
- clr and async reset mid-operation: clr asserted in the same cycle as a tick with charge requested → all levels 0 and counter 0 next cycle, with no increment applied. rst pulled low between edges → outputs return to reset values immediately, without waiting for clk.
- Channel independence: ch0 charge setting 2 while ch1 drain setting 1 from 50 → ch0 +2 and ch1 −1 per tick. Neither channel's flags are affected by the other.

Source files
------------

// File: rtl/power_bank.sv
// power_bank: multi-channel saturating power-level accumulator with depletion lockout
// Ports: clk, rst (async active-low), clr (sync clear of all channels),
//   powerSetting [2*NUM_CH] per-channel rate, powerMode [NUM_CH] 1=drain 0=charge,
//   powerOutput [WIDTH*NUM_CH] per-channel level, full/empty/lockout/active per-channel flags,
//   tick update strobe shared by all channels.
module power_bank #(
    parameter int NUM_CH        = 2,
    parameter int WIDTH         = 8,
    parameter int MAX_LEVEL     = 179,
    parameter int RECOVER_LEVEL = 16,
    parameter int TICK_DIV      = 1,
    parameter int RATE1         = 1,
    parameter int RATE2         = 2,
    parameter int RATE3         = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [2*NUM_CH-1:0]     powerSetting,
    input  logic [NUM_CH-1:0]       powerMode,
    output logic [WIDTH*NUM_CH-1:0] powerOutput,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       lockout,
    output logic [NUM_CH-1:0]       active,
    output logic                    tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic {NORMAL, LOCKOUT} state_t;
    logic [CW-1:0] cnt_q;
    assign tick = cnt_q == CW'(TICK_DIV - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else if (clr || tick) cnt_q <= '0;
        else cnt_q <= cnt_q + CW'(1);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] lvl_q;
        state_t           st_q;
        logic [1:0]       set;
        logic [WIDTH:0]   delta, sum, chg, drn;
        assign set = powerSetting[2*g +: 2];
        // One extra bit of headroom so charge overflow and drain underflow are detectable.
        always_comb begin
            delta = set == 2'd0 ? '0 :
                    set == 2'd1 ? (WIDTH+1)'(RATE1) :
                    set == 2'd2 ? (WIDTH+1)'(RATE2) : (WIDTH+1)'(RATE3);
            sum   = {1'b0, lvl_q} + delta;
            chg   = sum > (WIDTH+1)'(MAX_LEVEL) ? (WIDTH+1)'(MAX_LEVEL) : sum;
            drn   = delta > {1'b0, lvl_q} ? '0 : {1'b0, lvl_q} - delta;
        end
        // Reset starts locked out: a channel must be charged to RECOVER_LEVEL before draining.
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                lvl_q <= '0;
                st_q  <= LOCKOUT;
            end else if (clr) begin
                lvl_q <= '0;
                st_q  <= NORMAL;
            end else if (tick) begin
                if (!powerMode[g]) begin
                    lvl_q <= chg[WIDTH-1:0];
                    if (chg >= (WIDTH+1)'(RECOVER_LEVEL)) st_q <= NORMAL;
                end else if (st_q == NORMAL) begin
                    lvl_q <= drn[WIDTH-1:0];
                    if (drn == '0 && delta != '0) st_q <= LOCKOUT;
                end
            end
        assign powerOutput[WIDTH*g +: WIDTH] = lvl_q;
        assign full[g]    = lvl_q == WIDTH'(MAX_LEVEL);
        assign empty[g]   = lvl_q == '0;
        assign lockout[g] = st_q == LOCKOUT;
        assign active[g]  = powerMode[g] && set != 2'd0 && st_q == NORMAL && lvl_q != '0;
    end
endmodule

// File: tb/tb_power_bank.sv
// tb_power_bank: table-driven and scoreboard checks of power_bank at TICK_DIV 1 and 4
module tb_power_bank;
    typedef struct packed {
        logic [7:0] l0;
        logic [7:0] l1;
        logic [1:0] f;
        logic [1:0] e;
        logic [1:0] lk;
        logic [1:0] a;
        logic       t;
    } outs_t;
    typedef struct {
        logic       c;
        logic [3:0] s;
        logic [1:0] m;
        outs_t      e;
    } vec_t;
    typedef struct {
        string tag;
        bit    sel;
        outs_t exp;
    } sb_t;
    logic clk = 0, rst, clr;
    logic [3:0] set;
    logic [1:0] mode;
    logic [15:0] po0, po1;
    logic [1:0] f0, e0, lk0, a0, f1, e1, lk1, a1;
    logic t0, t1;
    int chk = 0, pass = 0;
    vec_t tbl[$];
    sb_t sb[$];
    always #5 clk = ~clk;
    power_bank u_dut (
        .clk(clk), .rst(rst), .clr(clr), .powerSetting(set), .powerMode(mode),
        .powerOutput(po0), .full(f0), .empty(e0), .lockout(lk0), .active(a0), .tick(t0)
    );
    power_bank #(.TICK_DIV(4)) u_div (
        .clk(clk), .rst(rst), .clr(clr), .powerSetting(set), .powerMode(mode),
        .powerOutput(po1), .full(f1), .empty(e1), .lockout(lk1), .active(a1), .tick(t1)
    );
    function automatic outs_t o(int l0, int l1, logic [1:0] f, logic [1:0] e,
                                logic [1:0] lk, logic [1:0] a, logic t);
        o = {8'(l0), 8'(l1), f, e, lk, a, t};
    endfunction
    function automatic vec_t mk(logic c, logic [3:0] s, logic [1:0] m, int l0, int l1,
                                logic [1:0] f, logic [1:0] e, logic [1:0] lk, logic [1:0] a);
        mk = '{c, s, m, o(l0, l1, f, e, lk, a, 1'b1)};
    endfunction
    function automatic outs_t obs(bit sel);
        obs = sel ? {po1[7:0], po1[15:8], f1, e1, lk1, a1, t1}
                  : {po0[7:0], po0[15:8], f0, e0, lk0, a0, t0};
    endfunction
    task automatic cmp(string tag, outs_t got, outs_t exp);
        chk++;
        if (got === exp) pass++;
        else $display("FAIL %s got l0=%0d l1=%0d f=%b e=%b lk=%b a=%b t=%b exp l0=%0d l1=%0d f=%b e=%b lk=%b a=%b t=%b",
                      tag, got.l0, got.l1, got.f, got.e, got.lk, got.a, got.t,
                      exp.l0, exp.l1, exp.f, exp.e, exp.lk, exp.a, exp.t);
    endtask
    task automatic step(logic c, logic [3:0] s, logic [1:0] m, outs_t e, bit sel, string tag);
        sb_t it;
        clr = c;
        set = s;
        mode = m;
        sb.push_back('{tag, sel, e});
        @(posedge clk);
        #1;
        it = sb.pop_front();
        cmp(it.tag, obs(it.sel), it.exp);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
    initial begin
        rst = 0; clr = 0; set = '0; mode = '0;
        tbl.push_back(mk(0, 4'b0011, 2'b00, 3, 0, 2'b00, 2'b10, 2'b11, 2'b00));
        tbl.push_back(mk(0, 4'b0011, 2'b00, 6, 0, 2'b00, 2'b10, 2'b11, 2'b00));
        tbl.push_back(mk(0, 4'b0011, 2'b00, 9, 0, 2'b00, 2'b10, 2'b11, 2'b00));
        tbl.push_back(mk(0, 4'b0011, 2'b00, 12, 0, 2'b00, 2'b10, 2'b11, 2'b00));
        tbl.push_back(mk(0, 4'b0011, 2'b00, 15, 0, 2'b00, 2'b10, 2'b11, 2'b00));
        tbl.push_back(mk(0, 4'b0011, 2'b00, 18, 0, 2'b00, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b0010, 2'b00, 179, 0, 2'b01, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b0010, 2'b00, 179, 0, 2'b01, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b0010, 2'b00, 179, 0, 2'b01, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b00, 179, 3, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b00, 179, 6, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b00, 179, 9, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b00, 179, 12, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b00, 179, 15, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b00, 179, 18, 2'b01, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 15, 2'b01, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 12, 2'b01, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 9, 2'b01, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 6, 2'b01, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(0, 4'b0100, 2'b10, 179, 5, 2'b01, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 2, 2'b01, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 0, 2'b01, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 0, 2'b01, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b0100, 2'b00, 179, 1, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 4'b1100, 2'b10, 179, 1, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(1, 4'b1111, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00));
        tbl.push_back(mk(0, 4'b0001, 2'b01, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00));
        tbl.push_back(mk(1, 4'b0000, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00));
        #12;
        cmp("reset_dut", obs(0), o(0, 0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b1));
        cmp("reset_div", obs(1), o(0, 0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0));
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 6; i++)
            step(tbl[i].c, tbl[i].s, tbl[i].m, tbl[i].e, 0, $sformatf("vec%0d", i));
        for (int k = 1; k <= 80; k++)
            step(0, 4'b0010, 2'b00, o(18 + 2*k, 0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b1), 0, "charge_up");
        for (int i = 6; i < tbl.size(); i++)
            step(tbl[i].c, tbl[i].s, tbl[i].m, tbl[i].e, 0, $sformatf("vec%0d", i));
        for (int k = 1; k <= 25; k++)
            step(0, 4'b1000, 2'b00, o(0, 2*k, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1), 0, "ch1_fill");
        for (int k = 1; k <= 5; k++)
            step(0, 4'b0110, 2'b10, o(2*k, 50 - k, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1), 0, "indep");
        #3;
        rst = 0;
        #1;
        cmp("async_rst_dut", obs(0), o(0, 0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b1));
        cmp("async_rst_div", obs(1), o(0, 0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0));
        @(negedge clk);
        rst = 1;
        step(1, 4'b0000, 2'b00, o(0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0), 1, "div_clr");
        for (int i = 1; i <= 200; i++)
            step(0, 4'b0010, 2'b00, o(2*(i/4), 0, 2'b00, i < 4 ? 2'b11 : 2'b10, 2'b00, 2'b00, (i % 4) == 3),
                 1, "div_charge");
        for (int j = 1; j <= 12; j++)
            step(0, 4'b0001, 2'b01, o(100 - j/4, 0, 2'b00, 2'b10, 2'b00, 2'b01, (j % 4) == 3),
                 1, "div_drain");
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
